// File: rtl/frame_line_reader.sv
// Line-buffer read side of a double-buffered scanline renderer: issues line-RAM reads
// per pixel strobe, swaps banks at the end of the visible line and emits palette indices.
module frame_line_reader #(
    parameter int         H_VISIBLE = 640,
    parameter logic [3:0] BG_INDEX  = 4'h0
) (
    input  logic       Clk50,
    input  logic       Reset,
    input  logic       pix_en,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic       wr_line_ready,
    output logic       rd_bank,
    output logic       rd_en,
    output logic [9:0] rd_addr,
    input  logic [3:0] rd_data,
    output logic [3:0] pix_index,
    output logic       pix_valid,
    output logic       rd_line_ack,
    output logic [7:0] underrun_cnt
);

    localparam logic [9:0] SWAP_COL = 10'(H_VISIBLE);

    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,
        STREAM     = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       swap_s;
    logic       take_s;
    logic       underrun_s;
    logic       read_s;
    logic [7:0] cnt_nxt_s;
    logic       s1_valid_r;
    logic       s1_read_r;
    logic       s2_valid_r;
    logic       s2_read_r;
    logic       unused_s;

    // DrawY is a debug-only passenger
    assign unused_s = ^DrawY;

    // Swap-point decode, read-slot decode, counter saturation and next state
    always_comb begin
        swap_s      = 1'b0;
        take_s      = 1'b0;
        underrun_s  = 1'b0;
        read_s      = 1'b0;
        cnt_nxt_s   = underrun_cnt;
        state_nxt_s = state_r;

        swap_s     = pix_en && (DrawX == SWAP_COL);
        take_s     = swap_s && wr_line_ready;
        underrun_s = swap_s && !wr_line_ready && (state_r == STREAM);
        read_s     = pix_en && blank && (DrawX < SWAP_COL) && (state_r == STREAM);

        if (underrun_s && (underrun_cnt != 8'hFF)) begin
            cnt_nxt_s = underrun_cnt + 8'd1;
        end else begin
            cnt_nxt_s = underrun_cnt;
        end

        case (state_r)
            WAIT_FIRST: begin
                if (take_s) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = WAIT_FIRST;
                end
            end
            STREAM:  state_nxt_s = STREAM;
            default: state_nxt_s = WAIT_FIRST;
        endcase
    end

    // State register
    always_ff @(posedge Clk50 or negedge Reset) begin
        if (!Reset) begin
            state_r <= WAIT_FIRST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bank ownership, swap acknowledge and underrun counter
    always_ff @(posedge Clk50 or negedge Reset) begin
        if (!Reset) begin
            rd_bank      <= 1'b0;
            rd_line_ack  <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            if (take_s) begin
                rd_bank <= ~rd_bank;
            end else begin
                rd_bank <= rd_bank;
            end
            rd_line_ack  <= take_s;
            underrun_cnt <= cnt_nxt_s;
        end
    end

    // Stage 1: RAM request; the bank is sampled by the RAM with the request, so a
    // later swap cannot redirect a read already issued
    always_ff @(posedge Clk50 or negedge Reset) begin
        if (!Reset) begin
            rd_en      <= 1'b0;
            rd_addr    <= 10'd0;
            s1_valid_r <= 1'b0;
            s1_read_r  <= 1'b0;
        end else begin
            rd_en      <= read_s;
            s1_valid_r <= pix_en;
            s1_read_r  <= read_s;
            if (read_s) begin
                rd_addr <= DrawX;
            end else begin
                rd_addr <= rd_addr;
            end
        end
    end

    // Stage 2 (RAM latency) and stage 3 (output register)
    always_ff @(posedge Clk50 or negedge Reset) begin
        if (!Reset) begin
            s2_valid_r <= 1'b0;
            s2_read_r  <= 1'b0;
            pix_valid  <= 1'b0;
            pix_index  <= BG_INDEX;
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_read_r  <= s1_read_r;
            pix_valid  <= s2_valid_r;
            if (s2_read_r) begin
                pix_index <= rd_data;
            end else begin
                pix_index <= BG_INDEX;
            end
        end
    end

endmodule
